// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one read/write port pair of a word-addressed memory
//            between an instruction-fetch requester and a load/store
//            requester. It uses valid/ready handshakes on each side and
//            sequences each transaction through IDLE -> ACCESS -> RESP.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH    = 10,
    parameter bit DATA_PRIORITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    // instruction-fetch requester
    input  logic                  inst_req_valid,
    output logic                  inst_req_ready,
    input  logic [31:0]           inst_addr,
    output logic                  inst_resp_valid,
    input  logic                  inst_resp_ready,
    output logic [31:0]           inst_rdata,
    // load/store requester
    input  logic                  data_req_valid,
    output logic                  data_req_ready,
    input  logic                  data_req_wen,
    input  logic [31:0]           data_addr,
    input  logic [31:0]           data_wdata,
    output logic                  data_resp_valid,
    input  logic                  data_resp_ready,
    output logic [31:0]           data_rdata,
    // memory side (write port and read port 1)
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic                  mem_wren,
    output logic                  mem_rden,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic c_own_inst = 1'b0;
    localparam logic c_own_data = 1'b1;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rbuf_q, rbuf_d;

    logic [ADDR_WIDTH-1:0] w_inst_word;
    logic [ADDR_WIDTH-1:0] w_data_word;
    logic                  w_grant_inst;
    logic                  w_grant_data;
    logic                  w_idle;
    logic                  w_access;
    logic                  w_resp;
    logic                  w_unused_addr;

    // Byte address to word index: byte-offset bits dropped, high bits wrap.
    assign w_inst_word   = {2'b00, inst_addr[ADDR_WIDTH-1:2]};
    assign w_data_word   = {2'b00, data_addr[ADDR_WIDTH-1:2]};
    assign w_unused_addr = ^{inst_addr, data_addr};

    // Combinational grant: a lone requester wins; conflicts go by priority
    // or alternate away from whoever was granted last.
    always_comb begin
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        if (data_req_valid &&
            (!inst_req_valid || (DATA_PRIORITY == 1'b1) || (last_grant_q == c_own_inst))) begin
            w_grant_data = 1'b1;
        end else if (inst_req_valid) begin
            w_grant_inst = 1'b1;
        end
    end

    // Next-state logic: accept in IDLE, one memory cycle in ACCESS, hold in RESP.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        case (state_q)
            ST_IDLE: begin
                if (w_grant_inst) begin
                    owner_d      = c_own_inst;
                    last_grant_d = c_own_inst;
                    addr_d       = w_inst_word;
                    wen_d        = 1'b0;
                    wdata_d      = 32'h0;
                    state_d      = ST_ACCESS;
                end else if (w_grant_data) begin
                    owner_d      = c_own_data;
                    last_grant_d = c_own_data;
                    addr_d       = w_data_word;
                    wen_d        = data_req_wen;
                    wdata_d      = data_wdata;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Stores acknowledge with zero; loads capture the async read.
                rbuf_d  = wen_q ? 32'h0 : mem_rdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (((owner_q == c_own_inst) && inst_resp_ready) ||
                    ((owner_q == c_own_data) && data_resp_ready)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and transaction registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= c_own_inst;
            last_grant_q <= c_own_data;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            rbuf_q       <= 32'h0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
        end
    end

    // Ready is masked by resetn so every output is low while reset is held.
    assign w_idle   = (state_q == ST_IDLE) && resetn;
    assign w_access = (state_q == ST_ACCESS);
    assign w_resp   = (state_q == ST_RESP);

    assign inst_req_ready  = w_idle && w_grant_inst;
    assign data_req_ready  = w_idle && w_grant_data;

    assign inst_resp_valid = w_resp && (owner_q == c_own_inst);
    assign data_resp_valid = w_resp && (owner_q == c_own_data);
    assign inst_rdata      = inst_resp_valid ? rbuf_q : 32'h0;
    assign data_rdata      = data_resp_valid ? rbuf_q : 32'h0;

    // Strobes are decoded purely from registers, so they cannot glitch.
    assign mem_wren  = w_access && wen_q;
    assign mem_rden  = w_access && !wen_q;
    assign mem_waddr = mem_wren ? addr_q : '0;
    assign mem_raddr = mem_rden ? addr_q : '0;
    assign mem_wdata = mem_wren ? wdata_q : 32'h0;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single read/write port pair of the ideal_mem word-addressed memory between two requesters of the multi-cycle MIPS core: instruction fetch (INST) and load/store (DATA).
- Uses valid/ready request and response handshakes on each requester side.
- Sequences every transaction through an IDLE/ACCESS/RESP state machine and returns read data in a registered response buffer.
- Sits between the core and ideal_mem. Drives the memory's write port and read port 1 only.

Parameters:
- ADDR_WIDTH, 10, memory address width; must equal the connected memory's ADDR_WIDTH.
- DATA_PRIORITY, 0, 0 = round-robin on conflicts; 1 = DATA always wins conflicts.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- inst_req_valid  input  1  INST request present.
- inst_req_ready  output  1  INST request accepted this cycle.
- inst_addr  input  32  INST byte address.
- inst_resp_valid  output  1  INST read data available.
- inst_resp_ready  input  1  INST consumes response.
- inst_rdata  output  32  INST read data.
- data_req_valid  input  1  DATA request present.
- data_req_ready  output  1  DATA request accepted this cycle.
- data_req_wen  input  1  1 = store, 0 = load.
- data_addr  input  32  DATA byte address.
- data_wdata  input  32  store data.
- data_resp_valid  output  1  DATA response available; load data or store acknowledge.
- data_resp_ready  input  1  DATA consumes response.
- data_rdata  output  32  load data; 0 for store acknowledge.
- mem_waddr  output  ADDR_WIDTH  to memory Waddr.
- mem_raddr  output  ADDR_WIDTH  to memory Raddr1.
- mem_wren  output  1  to memory Wren.
- mem_rden  output  1  to memory Rden1.
- mem_wdata  output  32  to memory Wdata.
- mem_rdata  input  32  from memory Rdata1; asynchronous read.

Behaviour:
- Reset: clk is the single clock; resetn is asynchronous and active-low. Reset forces:
  - state = IDLE, owner = INST, last_grant = DATA;
  - all outputs to 0, including mem_wren, which deasserts immediately;
  - response buffer to 0.
- Reset mid-operation: any in-flight transaction is dropped with no response. A write whose ACCESS cycle is cut by reset is not performed.
- Address mapping: word index = {2'b00, addr[ADDR_WIDTH-1:2]}.
  - addr[1:0] are ignored (no misalignment fault).
  - Bits above ADDR_WIDTH-1 are ignored, so out-of-range addresses wrap.
- IDLE state:
  - Grant decision is combinational.
  - Only one valid: grant that requester.
  - Both valid, DATA_PRIORITY=1: grant DATA.
  - Both valid, DATA_PRIORITY=0: grant the requester not equal to last_grant, so the first conflict after reset goes to INST.
  - The granted *_req_ready is high only in IDLE; the other requester's ready stays 0.
  - On the accepting edge, latch: owner, word address, wen (INST always 0), wdata; update last_grant; go to ACCESS.
- ACCESS state (exactly 1 cycle):
  - Read: mem_raddr = latched address, mem_rden = 1; at the edge, capture mem_rdata into the response buffer.
  - Write: mem_waddr = latched address, mem_wdata = latched data, mem_wren = 1; memory writes at this edge; response buffer = 0.
  - Next state is RESP.
  - mem_wren and mem_rden are 0 in all other states; address and data outputs are don't-care outside ACCESS but must not glitch mem_wren.
- RESP state:
  - The owner's *_resp_valid = 1 and *_rdata = response buffer.
  - Both stay stable until the owner's *_resp_ready = 1 at an edge, then go to IDLE.
  - The non-owner's resp_valid is 0.
  - No new request is accepted in RESP.
- Latency: accept at edge T; response valid from cycle T+2. Minimum 3 cycles per transaction; back-to-back throughput is 1 transaction per 3 cycles.
- Requester obligations: hold valid, addr, wdata and wen stable until ready. A valid dropped before acceptance is legal and is simply not granted.
- Read-after-write to the same address by consecutive transactions returns the new data, since the write completes before the next ACCESS.

Test Plan:
- INST read alone, memory word 5 = 32'h0c000025, inst_addr=32'h14, resp_ready tied 1 -> inst_req_ready high cycle 0; mem_rden/mem_raddr=5 cycle 1; inst_resp_valid with inst_rdata=32'h0c000025 cycle 2.
- DATA store then load at addr 32'h100, wdata 32'hdeadbeef -> mem_wren=1, mem_waddr=64 for one cycle; store ack data_rdata=0; load returns 32'hdeadbeef.
- Both valid every cycle, DATA_PRIORITY=0, resp_ready=1 -> grants alternate INST, DATA, INST, DATA…; one grant every 3 cycles.
- Same conflict with DATA_PRIORITY=1 -> only DATA granted while data_req_valid held; INST starved, ready stays 0.
- Response backpressure: inst_resp_ready low 5 cycles -> inst_resp_valid and inst_rdata stable; no new grant; IDLE resumes the cycle after ready rises.
- Reset asserted mid-ACCESS of a store to 32'h200 -> mem_wren drops immediately, memory word 128 unchanged; all outputs 0; first post-reset conflict is granted to INST.
